// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus: response codes, slave ids and
// the master-port state encoding.
package bus_pkg;

  typedef enum logic [1:0] {
    RESP_NONE  = 2'b00,
    RESP_READY = 2'b01,
    RESP_SPLIT = 2'b10,
    RESP_ERROR = 2'b11
  } resp_e;

  // Top two address bits select the slave; 00 is never decoded.
  typedef enum logic [1:0] {
    SLAVE_NONE = 2'b00,
    SLAVE_1    = 2'b01,
    SLAVE_2    = 2'b10,
    SLAVE_3    = 2'b11
  } slave_id_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ADDR,
    ST_WDATA,
    ST_WAIT,
    ST_RDATA,
    ST_SPLIT_WAIT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/bus_master_port_if.sv
// Client request/response handshake plus arbiter and serial bus wires seen by
// one bus master port.
interface bus_master_port_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [DATA_W-1:0] resp_rdata;
  logic              from_arb_grant;
  logic              to_arb_req_bus;
  logic              to_arb_bus_util;
  logic              to_addr_bus;
  logic              to_wdata_bus;
  logic              from_rdata_bus;
  logic [1:0]        from_response_bus;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  from_arb_grant, from_rdata_bus, from_response_bus,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output to_arb_req_bus, to_arb_bus_util, to_addr_bus, to_wdata_bus
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output from_arb_grant, from_rdata_bus, from_response_bus,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  to_arb_req_bus, to_arb_bus_util, to_addr_bus, to_wdata_bus
  );
endinterface

// File: rtl/bit_serialiser.sv
// Parallel-load, MSB-first shifter. The output is the register MSB, so it
// reads 0 whenever nothing is loaded or every bit has been shifted out.
module bit_serialiser #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic             clear,
  input  logic [WIDTH-1:0] data,
  output logic             bit_out,
  output logic             last
);
  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             busy;

  assign bit_out = shreg[WIDTH-1];
  assign last    = busy && (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      shreg <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (load) begin
      shreg <= data;
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (shift && busy) begin
      shreg <= {shreg[WIDTH-2:0], 1'b0};
      if (last) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/bus_master_port.sv
// Master-side serial bus port: turns one parallel client request into an
// arbitrated serial address/data transfer, including SPLIT release and resume.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  bus_master_port_if.master bus
);
  localparam int FRAME_W = ADDR_W + 1;
  localparam int RCNT_W  = $clog2(DATA_W);

  state_e              state;
  logic                req_ready_q;
  logic                arb_req_q;
  logic                util_q;
  logic                resp_valid_q;
  logic                resp_err_q;
  logic [DATA_W-1:0]   resp_rdata_q;

  logic                wr_q;
  logic [FRAME_W-1:0]  frame_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-2:0]   rshift_q;
  logic [RCNT_W-1:0]   rcnt_q;
  logic [7:0]          tcnt_q;

  resp_e               resp;
  logic                grant;
  logic                addr_bit, addr_last, wdata_bit, wdata_last;
  logic                addr_load, wdata_load, ser_clear;

  assign resp  = resp_e'(bus.from_response_bus);
  assign grant = bus.from_arb_grant;

  // A lost grant mid-frame must silence the buses on the same edge the
  // transaction is abandoned; clear outranks load inside the serialiser.
  assign addr_load  = (state == ST_REQ) && grant;
  assign wdata_load = (state == ST_ADDR) && addr_last && wr_q;
  assign ser_clear  = ((state == ST_ADDR) || (state == ST_WDATA)) && !grant;

  bit_serialiser #(.WIDTH(FRAME_W)) u_addr_ser (
    .clk     (clk),
    .reset   (reset),
    .load    (addr_load),
    .shift   (state == ST_ADDR),
    .clear   (ser_clear),
    .data    (frame_q),
    .bit_out (addr_bit),
    .last    (addr_last)
  );

  bit_serialiser #(.WIDTH(DATA_W)) u_wdata_ser (
    .clk     (clk),
    .reset   (reset),
    .load    (wdata_load),
    .shift   (state == ST_WDATA),
    .clear   (ser_clear),
    .data    (wdata_q),
    .bit_out (wdata_bit),
    .last    (wdata_last)
  );

  assign bus.req_ready       = req_ready_q;
  assign bus.to_arb_req_bus  = arb_req_q;
  assign bus.to_arb_bus_util = util_q;
  assign bus.to_addr_bus     = addr_bit;
  assign bus.to_wdata_bus    = wdata_bit;
  assign bus.resp_valid      = resp_valid_q;
  assign bus.resp_err        = resp_err_q;
  assign bus.resp_rdata      = resp_rdata_q;

  // NOTE: sequential state is only ever updated with <=, including from this
  // task, so every branch sees the pre-edge values of all registers.
  task automatic finish_txn(input logic err);
    state        <= ST_DONE;
    resp_valid_q <= 1'b1;
    resp_err_q   <= err;
    arb_req_q    <= 1'b0;
    util_q       <= 1'b0;
  endtask

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      req_ready_q  <= 1'b1;
      arb_req_q    <= 1'b0;
      util_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      wr_q         <= 1'b0;
      frame_q      <= '0;
      wdata_q      <= '0;
      rshift_q     <= '0;
      rcnt_q       <= '0;
      tcnt_q       <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            wr_q        <= bus.req_write;
            frame_q     <= {bus.req_write, bus.req_addr};
            wdata_q     <= bus.req_wdata;
            rshift_q    <= '0;
            rcnt_q      <= '0;
            tcnt_q      <= '0;
            req_ready_q <= 1'b0;
            arb_req_q   <= 1'b1;
            state       <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (grant) begin
            util_q <= 1'b1;
            state  <= ST_ADDR;
          end
        end

        ST_ADDR: begin
          if (!grant) begin
            finish_txn(1'b1);
          end else if (addr_last) begin
            tcnt_q <= '0;
            state  <= wr_q ? ST_WDATA : ST_WAIT;
          end
        end

        ST_WDATA: begin
          if (!grant) begin
            finish_txn(1'b1);
          end else if (wdata_last) begin
            tcnt_q <= '0;
            state  <= ST_WAIT;
          end
        end

        // SPLIT is checked first: an arbiter revoking the grant together
        // with SPLIT is a legitimate release, not a grant loss.
        ST_WAIT, ST_RDATA: begin
          if (resp == RESP_SPLIT) begin
            util_q <= 1'b0;
            tcnt_q <= '0;
            state  <= ST_SPLIT_WAIT;
          end else if (!grant || resp == RESP_ERROR) begin
            finish_txn(1'b1);
          end else if (resp == RESP_READY) begin
            if (state == ST_WAIT && wr_q) begin
              finish_txn(1'b0);
            end else if (rcnt_q == RCNT_W'(DATA_W - 1)) begin
              resp_rdata_q <= {rshift_q, bus.from_rdata_bus};
              finish_txn(1'b0);
            end else begin
              rshift_q <= {rshift_q[DATA_W-3:0], bus.from_rdata_bus};
              rcnt_q   <= rcnt_q + RCNT_W'(1);
              state    <= ST_RDATA;
            end
          end else if (tcnt_q == 8'(TIMEOUT - 1)) begin
            finish_txn(1'b1);
          end else begin
            tcnt_q <= tcnt_q + 8'd1;
          end
        end

        // Address was accepted before the split, so resume straight into
        // the response phase with the received bit count intact.
        ST_SPLIT_WAIT: begin
          if (grant) begin
            util_q <= 1'b1;
            state  <= (rcnt_q != '0) ? ST_RDATA : ST_WAIT;
          end
        end

        ST_DONE: begin
          req_ready_q <= 1'b1;
          state       <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_port.sv
// Directed bench for bus_master_port: frame contents, read/write completion,
// SPLIT resume, timeout, grant loss, ERROR response and mid-transfer reset.
module tb_bus_master_port;
  import bus_pkg::*;

  localparam int ADDR_W  = 14;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 255;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  bus_master_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  bus_master_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_txn(input logic wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic collect_addr(output logic [ADDR_W:0] frame);
    frame = '0;
    for (int i = 0; i <= ADDR_W; i++) begin
      frame = {frame[ADDR_W-1:0], bus.to_addr_bus};
      tick();
    end
  endtask

  task automatic collect_wdata(output logic [DATA_W-1:0] word);
    word = '0;
    for (int i = 0; i < DATA_W; i++) begin
      word = {word[DATA_W-2:0], bus.to_wdata_bus};
      tick();
    end
  endtask

  logic [ADDR_W:0]   frame;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] rd;
  int                util_hi, addr_hi, req_lo, n_wait;
  logic              seen;

  initial begin
    reset                 = 1'b0;
    bus.req_valid         = 1'b0;
    bus.req_write         = 1'b0;
    bus.req_addr          = '0;
    bus.req_wdata         = '0;
    bus.from_arb_grant    = 1'b0;
    bus.from_rdata_bus    = 1'b0;
    bus.from_response_bus = RESP_NONE;
    tick();
    tick();
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_arb_req", bus.to_arb_req_bus, 0);
    check("rst_util", bus.to_arb_bus_util, 0);
    check("rst_addr_bus", bus.to_addr_bus, 0);
    check("rst_wdata_bus", bus.to_wdata_bus, 0);
    reset = 1'b1;
    tick();

    // 1: write 0x5A to 0x10A3, grant two edges after request
    start_txn(1'b1, 14'h10A3, 8'h5A);
    check("t1_req_held", bus.to_arb_req_bus, 1);
    check("t1_not_ready", bus.req_ready, 0);
    check("t1_util_pre_grant", bus.to_arb_bus_util, 0);
    tick();
    bus.from_arb_grant = 1'b1;
    tick();
    check("t1_util_addr", bus.to_arb_bus_util, 1);
    collect_addr(frame);
    check("t1_addr_frame", frame, 15'b101_0000_1010_0011);
    collect_wdata(word);
    check("t1_wdata", word, 8'h5A);
    check("t1_wait_no_resp", bus.resp_valid, 0);
    check("t1_wait_addr_idle", bus.to_addr_bus, 0);
    tick();
    bus.from_response_bus = RESP_READY;
    tick();
    bus.from_response_bus = RESP_NONE;
    bus.from_arb_grant    = 1'b0;
    check("t1_resp_valid", bus.resp_valid, 1);
    check("t1_resp_err", bus.resp_err, 0);
    check("t1_done_req", bus.to_arb_req_bus, 0);
    check("t1_done_util", bus.to_arb_bus_util, 0);
    tick();
    check("t1_pulse_end", bus.resp_valid, 0);
    check("t1_idle_ready", bus.req_ready, 1);

    // 2: read 0x2004, slave returns 0xC3 with READY every cycle
    start_txn(1'b0, 14'h2004, 8'h00);
    bus.from_arb_grant = 1'b1;
    tick();
    collect_addr(frame);
    check("t2_addr_frame", frame, 15'b010_0000_0000_0100);
    rd = 8'hC3;
    for (int i = 0; i < DATA_W; i++) begin
      bus.from_response_bus = RESP_READY;
      bus.from_rdata_bus    = rd[DATA_W-1-i];
      tick();
    end
    bus.from_response_bus = RESP_NONE;
    bus.from_rdata_bus    = 1'b0;
    bus.from_arb_grant    = 1'b0;
    check("t2_resp_valid", bus.resp_valid, 1);
    check("t2_resp_err", bus.resp_err, 0);
    check("t2_rdata", bus.resp_rdata, 8'hC3);
    tick();

    // 3: read 0x3155, SPLIT after 3 bits, regrant 20 cycles later
    start_txn(1'b0, 14'h3155, 8'h00);
    bus.from_arb_grant = 1'b1;
    tick();
    collect_addr(frame);
    check("t3_addr_frame", frame, 15'b011_0001_0101_0101);
    rd = 8'hA6;
    for (int i = 0; i < 3; i++) begin
      bus.from_response_bus = RESP_READY;
      bus.from_rdata_bus    = rd[DATA_W-1-i];
      tick();
    end
    bus.from_response_bus = RESP_SPLIT;
    bus.from_arb_grant    = 1'b0;
    tick();
    bus.from_response_bus = RESP_NONE;
    util_hi = 0;
    addr_hi = 0;
    req_lo  = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.to_arb_bus_util) util_hi++;
      if (bus.to_addr_bus || bus.to_wdata_bus) addr_hi++;
      if (!bus.to_arb_req_bus) req_lo++;
      if (i == 19) bus.from_arb_grant = 1'b1;
      tick();
    end
    check("t3_split_util_low", util_hi, 0);
    check("t3_split_buses_low", addr_hi, 0);
    check("t3_split_req_held", req_lo, 0);
    check("t3_regrant_util", bus.to_arb_bus_util, 1);
    for (int i = 3; i < DATA_W; i++) begin
      if (bus.to_addr_bus) addr_hi++;
      bus.from_response_bus = RESP_READY;
      bus.from_rdata_bus    = rd[DATA_W-1-i];
      tick();
    end
    bus.from_response_bus = RESP_NONE;
    bus.from_rdata_bus    = 1'b0;
    bus.from_arb_grant    = 1'b0;
    check("t3_no_addr_resend", addr_hi, 0);
    check("t3_resp_valid", bus.resp_valid, 1);
    check("t3_resp_err", bus.resp_err, 0);
    check("t3_rdata", bus.resp_rdata, 8'hA6);
    tick();

    // 4: write with no response: error exactly TIMEOUT cycles after WAIT entry
    start_txn(1'b1, 14'h1000, 8'h33);
    bus.from_arb_grant = 1'b1;
    tick();
    collect_addr(frame);
    collect_wdata(word);
    check("t4_wdata", word, 8'h33);
    n_wait = 0;
    seen   = 1'b0;
    while (!seen && n_wait < TIMEOUT + 40) begin
      tick();
      n_wait++;
      if (bus.resp_valid) seen = 1'b1;
    end
    check("t4_timeout_seen", seen, 1);
    check("t4_timeout_cycles", n_wait, TIMEOUT);
    check("t4_timeout_err", bus.resp_err, 1);
    bus.from_arb_grant = 1'b0;
    tick();

    // 5a: grant dropped while address bit 5 is on the bus
    start_txn(1'b1, 14'h1FFF, 8'h00);
    bus.from_arb_grant = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    bus.from_arb_grant = 1'b0;
    tick();
    check("t5a_resp_valid", bus.resp_valid, 1);
    check("t5a_resp_err", bus.resp_err, 1);
    check("t5a_addr_released", bus.to_addr_bus, 0);
    check("t5a_util", bus.to_arb_bus_util, 0);
    tick();
    check("t5a_idle_ready", bus.req_ready, 1);

    // 5b: ERROR response in WAIT
    start_txn(1'b0, 14'h2ABC, 8'h00);
    bus.from_arb_grant = 1'b1;
    tick();
    collect_addr(frame);
    bus.from_response_bus = RESP_ERROR;
    tick();
    bus.from_response_bus = RESP_NONE;
    bus.from_arb_grant    = 1'b0;
    check("t5b_resp_valid", bus.resp_valid, 1);
    check("t5b_resp_err", bus.resp_err, 1);
    tick();

    // 6: reset asserted in the middle of write data
    start_txn(1'b1, 14'h1555, 8'hFF);
    bus.from_arb_grant = 1'b1;
    tick();
    collect_addr(frame);
    for (int i = 0; i < 3; i++) tick();
    check("t6_wdata_active", bus.to_wdata_bus, 1);
    reset = 1'b0;
    tick();
    check("t6_rst_ready", bus.req_ready, 1);
    check("t6_rst_util", bus.to_arb_bus_util, 0);
    check("t6_rst_req", bus.to_arb_req_bus, 0);
    check("t6_rst_addr", bus.to_addr_bus, 0);
    check("t6_rst_wdata", bus.to_wdata_bus, 0);
    check("t6_rst_resp_valid", bus.resp_valid, 0);
    reset              = 1'b1;
    bus.from_arb_grant = 1'b0;
    tick();
    check("t6_post_resp_valid", bus.resp_valid, 0);
    check("t6_post_ready", bus.req_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
